// File: rtl/hazard_sched.sv
// hazard_sched: load-use, taken-branch and multi-cycle MDU hazard control for the 5-stage core.
// Define HAZARD_STATS_EN to add saturating stall_cnt / flush_cnt outputs.
module hazard_sched #(
    parameter logic [5:0] LW_OP   = 6'b100011,
    parameter logic [5:0] NOOP_OP = 6'b111111,
    parameter logic [5:0] MDU_OP  = 6'b011100,
    parameter int unsigned MDU_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] ex_rd,
    input  logic [5:0] ex_operation,
    input  logic       branch_taken,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       id_ex_write,
    output logic       id_ex_bubble,
    output logic       ex_mem_bubble,
`ifdef HAZARD_STATS_EN
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
`endif
    output logic       mdu_busy
);
    typedef enum logic {RUN, MDU_HOLD} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       retire_q, retire_d;
    logic       live, run, load_use, mdu_entry, hold, br, lu;

    assign live      = ex_operation != NOOP_OP;
    assign run       = state_q == RUN;
    assign load_use  = live && ex_operation == LW_OP && ex_rd != 5'd0 &&
                       (ex_rd == id_rs || ex_rd == id_rt);
    // The MDU op is still in EX during its retire cycle; it must not re-enter the hold.
    assign mdu_entry = run && !branch_taken && live && ex_operation == MDU_OP && !retire_q;
    assign hold      = !run || mdu_entry;
    assign br        = run && branch_taken;
    assign lu        = run && !branch_taken && !mdu_entry && load_use;

    assign pc_write      = !rst && !hold && !lu;
    assign if_id_write   = !rst && !hold && !lu;
    assign id_ex_write   = !rst && !hold;
    assign if_id_flush   = rst || br;
    assign id_ex_bubble  = rst || br || lu;
    assign ex_mem_bubble = rst || hold;
    assign mdu_busy      = !rst && hold;

    always_comb begin
        state_d  = mdu_entry ? MDU_HOLD : (!run && cnt_q == 4'd1) ? RUN : state_q;
        cnt_d    = mdu_entry ? 4'(MDU_LAT - 1) : !run ? cnt_q - 4'd1 : 4'd0;
        retire_d = !run && cnt_q == 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            cnt_q    <= 4'd0;
            retire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retire_q <= retire_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_q, flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 16'd0;
            flush_q <= 16'd0;
        end else begin
            if (!pc_write && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
            if (if_id_flush && flush_q != 16'hFFFF) flush_q <= flush_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`endif
endmodule

// File: tb/tb_hazard_sched.sv
// tb_hazard_sched: table vectors, hand-written MDU/reset sequences and random stimulus vs a cycle model.
module tb_hazard_sched;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] NOOP = 6'b111111;
    localparam logic [5:0] MDU  = 6'b011100;
    localparam int MDU_LAT = 4;

    // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble, mdu_busy}
    localparam logic [6:0] RST_V  = 7'b0010110;
    localparam logic [6:0] RUN_V  = 7'b1101000;
    localparam logic [6:0] LU_V   = 7'b0001100;
    localparam logic [6:0] BR_V   = 7'b1111100;
    localparam logic [6:0] HOLD_V = 7'b0000011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
    logic [5:0] ex_operation = '0;
    logic branch_taken = 1'b0;
    logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble, mdu_busy;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    int compared = 0;
    int mismatched = 0;
    int m_hold = 0;
    bit m_retire = 1'b0;
    int m_stall = 0;
    int m_flush = 0;

    always #5 clk = ~clk;

    hazard_sched #(.MDU_LAT(MDU_LAT)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd),
        .ex_operation(ex_operation), .branch_taken(branch_taken),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
`ifdef HAZARD_STATS_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .mdu_busy(mdu_busy)
    );

    typedef struct {
        logic       r;
        logic [4:0] rs, rt, rd;
        logic [5:0] op;
        logic       br;
        logic [6:0] want;
    } vec_t;

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %b want %b", nm, got, want);
        end
    endtask

    function automatic logic [6:0] model_out(input logic r, input logic [4:0] rs, rt, rd,
                                             input logic [5:0] op, input logic br);
        if (r) return RST_V;
        if (m_hold > 0) return HOLD_V;
        if (br) return BR_V;
        if (op == MDU && !m_retire) return HOLD_V;
        if (op == LW && rd != 0 && (rd == rs || rd == rt)) return LU_V;
        return RUN_V;
    endfunction

    task automatic step(input logic r, input logic [4:0] rs, rt, rd, input logic [5:0] op,
                        input logic br, input logic chk, input logic [6:0] want, input string nm);
        logic [6:0] e;
        @(negedge clk);
        rst = r; id_rs = rs; id_rt = rt; ex_rd = rd; ex_operation = op; branch_taken = br;
        if (r) begin
            m_hold = 0; m_retire = 1'b0; m_stall = 0; m_flush = 0;
        end
        #1;
        e = model_out(r, rs, rt, rd, op, br);
        check({nm, "_model"}, 16'({pc_write, if_id_write, if_id_flush, id_ex_write,
                                   id_ex_bubble, ex_mem_bubble, mdu_busy}), 16'(e));
        if (chk)
            check({nm, "_const"}, 16'({pc_write, if_id_write, if_id_flush, id_ex_write,
                                       id_ex_bubble, ex_mem_bubble, mdu_busy}), 16'(want));
`ifdef HAZARD_STATS_EN
        check({nm, "_stall_cnt"}, stall_cnt, 16'(m_stall));
        check({nm, "_flush_cnt"}, flush_cnt, 16'(m_flush));
`endif
        @(posedge clk);
        if (!r) begin
            if (!e[6] && m_stall < 65535) m_stall++;
            if (e[4] && m_flush < 65535) m_flush++;
            if (m_hold > 0) begin
                m_hold--;
                m_retire = (m_hold == 0);
            end else begin
                if (!br && op == MDU && !m_retire) m_hold = MDU_LAT - 1;
                m_retire = 1'b0;
            end
        end
    endtask

    initial begin
        vec_t tbl[10];
        int busy;
        tbl[0] = '{1'b1, 5'd0, 5'd0, 5'd0, 6'd0, 1'b0, RST_V};
        tbl[1] = '{1'b0, 5'd8, 5'd0, 5'd8, 6'd0, 1'b0, RUN_V};
        tbl[2] = '{1'b0, 5'd8, 5'd3, 5'd8, LW,   1'b0, LU_V};
        tbl[3] = '{1'b0, 5'd8, 5'd3, 5'd8, NOOP, 1'b0, RUN_V};
        tbl[4] = '{1'b0, 5'd0, 5'd0, 5'd0, LW,   1'b0, RUN_V};
        tbl[5] = '{1'b0, 5'd1, 5'd9, 5'd9, LW,   1'b0, LU_V};
        tbl[6] = '{1'b0, 5'd1, 5'd2, 5'd9, LW,   1'b0, RUN_V};
        tbl[7] = '{1'b0, 5'd1, 5'd5, 5'd5, LW,   1'b1, BR_V};
        tbl[8] = '{1'b0, 5'd1, 5'd2, 5'd3, 6'd0, 1'b1, BR_V};
        tbl[9] = '{1'b0, 5'd4, 5'd4, 5'd4, NOOP, 1'b0, RUN_V};
        for (int i = 0; i < 10; i++)
            step(tbl[i].r, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].op, tbl[i].br,
                 1'b1, tbl[i].want, $sformatf("table%0d", i));

        busy = 0;
        step(1'b0, 5'd1, 5'd2, 5'd3, MDU, 1'b0, 1'b1, HOLD_V, "mdu_c1");
        busy += mdu_busy;
        step(1'b0, 5'd1, 5'd2, 5'd3, MDU, 1'b1, 1'b1, HOLD_V, "mdu_c2_br_ignored");
        busy += mdu_busy;
        step(1'b0, 5'd3, 5'd2, 5'd3, MDU, 1'b0, 1'b1, HOLD_V, "mdu_c3");
        busy += mdu_busy;
        step(1'b0, 5'd1, 5'd2, 5'd3, MDU, 1'b0, 1'b1, HOLD_V, "mdu_c4");
        busy += mdu_busy;
        step(1'b0, 5'd1, 5'd2, 5'd3, MDU, 1'b0, 1'b1, RUN_V, "mdu_retire");
        busy += mdu_busy;
        check("mdu_busy_cycles", 16'(busy), 16'd4);
        step(1'b0, 5'd1, 5'd2, 5'd3, 6'd0, 1'b0, 1'b1, RUN_V, "mdu_after");

        step(1'b0, 5'd1, 5'd2, 5'd3, MDU, 1'b0, 1'b1, HOLD_V, "rmdu_c1");
        step(1'b0, 5'd1, 5'd2, 5'd3, MDU, 1'b0, 1'b1, HOLD_V, "rmdu_c2");
        step(1'b1, 5'd1, 5'd2, 5'd3, MDU, 1'b0, 1'b1, RST_V, "rmdu_reset");
        step(1'b0, 5'd1, 5'd2, 5'd3, 6'd0, 1'b0, 1'b1, RUN_V, "rmdu_release");

        for (int i = 0; i < 400; i++) begin
            logic [5:0] op;
            case ($urandom_range(4))
                0: op = LW;
                1: op = MDU;
                2: op = NOOP;
                3: op = 6'd0;
                default: op = 6'($urandom);
            endcase
            step($urandom_range(39) == 0, 5'($urandom_range(3)), 5'($urandom_range(3)),
                 5'($urandom_range(3)), op, $urandom_range(7) == 0, 1'b0, RUN_V,
                 $sformatf("rand%0d", i));
        end

`ifdef HAZARD_STATS_EN
        step(1'b1, 5'd0, 5'd0, 5'd0, 6'd0, 1'b0, 1'b1, RST_V, "st_reset");
        step(1'b0, 5'd8, 5'd0, 5'd8, LW, 1'b0, 1'b1, LU_V, "st_lu");
        step(1'b0, 5'd8, 5'd0, 5'd8, NOOP, 1'b0, 1'b1, RUN_V, "st_noop");
        for (int i = 0; i < 4; i++)
            step(1'b0, 5'd1, 5'd2, 5'd3, MDU, 1'b0, 1'b1, HOLD_V, $sformatf("st_mdu%0d", i));
        step(1'b0, 5'd1, 5'd2, 5'd3, MDU, 1'b0, 1'b1, RUN_V, "st_retire");
        step(1'b0, 5'd1, 5'd2, 5'd3, 6'd0, 1'b1, 1'b1, BR_V, "st_branch");
        step(1'b0, 5'd1, 5'd2, 5'd3, 6'd0, 1'b0, 1'b1, RUN_V, "st_tail");
        @(negedge clk);
        #1;
        check("stats_stall_total", stall_cnt, 16'd5);
        check("stats_flush_total", flush_cnt, 16'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
